// File: rtl/act_lut_scheduler.sv
// act_lut_scheduler: shares one combinational activation LUT among N_REQ
// neuron requesters. Round-robin grant, then LUT lookup, then linear
// interpolation between adjacent entries. Returns a tagged result via valid/ready.
//
// Optional feature macro: ACT_LUT_SCHED_INTERP_EN
//   defined   -> linear interpolation between base and next entry
//   undefined -> step approximation (result = base). No multiplier is built.
//                FSM and latency are the same in both builds.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is a one-hot, combinational grant)
//   req_data          packed signed pre-activations, requester i at [i*IN_W +: IN_W]
//   lut_addr          registered LUT address
//   lut_base/next     LUT entries at lut_addr and lut_addr+1
//   resp_valid/ready  result handshake
//   resp_id/data      served requester index and signed result
module act_lut_scheduler #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned IN_W   = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*IN_W-1:0]     req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [3:0]                lut_addr,
    input  logic [DATA_W-1:0]         lut_base,
    input  logic [DATA_W-1:0]         lut_next,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(N_REQ)-1:0]  resp_id,
    output logic [DATA_W-1:0]         resp_data
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned ADDR_W = IN_W - FRAC_W;
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DIFF_W + FRAC_W + 1;
    // Most positive segment: its upper neighbour is the most negative entry.
    localparam logic [3:0]  TOP_SEG = 4'((1 << (ADDR_W - 1)) - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, CALC, RESP} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [FRAC_W-1:0]   frac_q;
    logic [DATA_W-1:0]   base_q;
    logic [DATA_W-1:0]   next_q;

    logic                gnt_vld;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     cand;
    logic [IN_W-1:0]     sel_data;
    logic [DATA_W-1:0]   calc_res;

    // Round-robin search starting at rr_ptr; ID_W-bit wrap gives the modulo.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            cand = rr_ptr + ID_W'(j);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // The accept strobe exists only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign sel_data = req_data[32'(gnt_id) * IN_W +: IN_W];

`ifdef ACT_LUT_SCHED_INTERP_EN
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;

    // base + floor(diff*frac / 2^FRAC_W). This result stays between base and next.
    always_comb begin
        diff     = DIFF_W'($signed(next_q)) - DIFF_W'($signed(base_q));
        prod     = PROD_W'(diff) * $signed(PROD_W'({1'b0, frac_q}));
        sum      = PROD_W'($signed(base_q)) + (prod >>> FRAC_W);
        calc_res = DATA_W'(sum);
    end
`else
    logic unused_step;

    // The step approximation ignores the fraction and the next entry.
    assign unused_step = ^{frac_q, next_q};

    always_comb begin
        calc_res = base_q;
    end
`endif

    // Sequencer: grant -> lookup -> calc -> hold response until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            frac_q     <= '0;
            base_q     <= '0;
            next_q     <= '0;
            lut_addr   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        lut_addr <= sel_data[IN_W-1:FRAC_W];
                        frac_q   <= sel_data[FRAC_W-1:0];
                        id_q     <= gnt_id;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    base_q <= lut_base;
                    next_q <= (lut_addr == TOP_SEG) ? lut_base : lut_next;
                    state  <= CALC;
                end
                CALC: begin
                    resp_data  <= calc_res;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= id_q + ID_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
